tia_player_graphics_shifter: RTL

Parametrised, clocked successor to the TIA player graphics register. Holds a new/old (vertical-delay) graphics pair per player channel, performs the cross-channel new-to-old copy on every write, and serialises the selected graphics byte into a per-channel pixel stream with programmable horizontal stretch and optional reflection. Sits between the TIA register-write decode and the playfield/collision/priority logic.

---
 rtl/tia_graphics_pkg.sv | 23 ++
 rtl/tia_graphics_serializer_channel.sv | 78 +++++++
 rtl/tia_player_graphics_shifter.sv | 66 ++++++
 3 files changed

// File: rtl/tia_graphics_pkg.sv
// Shared constants and helpers for the TIA player graphics shifter.
package tia_graphics_pkg;

  localparam logic [1:0] SCALE_1 = 2'b00;
  localparam logic [1:0] SCALE_2 = 2'b01;
  localparam logic [1:0] SCALE_4 = 2'b10;
  localparam logic [1:0] SCALE_8 = 2'b11;

  // Number of clocks each pixel is held, minus one.
  function automatic logic [2:0] stretch_last(input logic [1:0] code);
    case (code)
      SCALE_1: return 3'd0;
      SCALE_2: return 3'd1;
      SCALE_4: return 3'd3;
      default: return 3'd7;
    endcase
  endfunction

  function automatic int idx_width(input int width);
    return (width <= 2) ? 1 : $clog2(width);
  endfunction

endpackage

// File: rtl/tia_graphics_serializer_channel.sv
// One player channel: bit index, stretch counter, busy flag and pixel mux.
// Reflection is only built when TIA_GRAPHICS_REFLECT_EN is defined.
module tia_graphics_serializer_channel
  import tia_graphics_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [WIDTH-1:0] sel,
  input  logic             refl,
  input  logic             start,
  input  logic [1:0]       scale,
  output logic             pix,
  output logic             busy
);

  localparam int            IW       = idx_width(WIDTH);
  localparam logic [IW-1:0] LAST_IDX = IW'(WIDTH - 1);

  logic [IW-1:0] idx_q, idx_d;
  logic [2:0]    cnt_q, cnt_d;
  logic [1:0]    scale_q, scale_d;
  logic          busy_q, busy_d;
  logic [IW-1:0] bit_sel;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      idx_q   <= '0;
      cnt_q   <= '0;
      scale_q <= SCALE_1;
      busy_q  <= 1'b0;
    end else begin
      idx_q   <= idx_d;
      cnt_q   <= cnt_d;
      scale_q <= scale_d;
      busy_q  <= busy_d;
    end
  end

  // A start always wins, so a start while busy restarts from bit 0.
  always_comb begin
    idx_d   = idx_q;
    cnt_d   = cnt_q;
    scale_d = scale_q;
    busy_d  = busy_q;
    if (start) begin
      idx_d   = '0;
      cnt_d   = '0;
      scale_d = scale;
      busy_d  = 1'b1;
    end else if (busy_q) begin
      if (cnt_q == stretch_last(scale_q)) begin
        cnt_d = '0;
        if (idx_q == LAST_IDX) begin
          idx_d  = '0;
          busy_d = 1'b0;
        end else begin
          idx_d = idx_q + IW'(1);
        end
      end else begin
        cnt_d = cnt_q + 3'd1;
      end
    end
  end

`ifdef TIA_GRAPHICS_REFLECT_EN
  assign bit_sel = refl ? idx_q : (LAST_IDX - idx_q);
`else
  logic unused_refl;
  assign unused_refl = refl;
  assign bit_sel     = LAST_IDX - idx_q;
`endif

  assign pix  = busy_q & sel[bit_sel];
  assign busy = busy_q;

endmodule

// File: rtl/tia_player_graphics_shifter.sv
// TIA player graphics: new/old register pairs with cross-channel copy, feeding
// one serializer per channel. Optional reflection via TIA_GRAPHICS_REFLECT_EN.
module tia_player_graphics_shifter
  import tia_graphics_pkg::*;
#(
  parameter int WIDTH    = 8,
  parameter int CHANNELS = 2
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic [WIDTH-1:0]      d,
  input  logic [CHANNELS-1:0]   wr,
  input  logic [CHANNELS-1:0]   vdel,
  input  logic [CHANNELS-1:0]   refl,
  input  logic [CHANNELS-1:0]   start,
  input  logic [2*CHANNELS-1:0] scale,
  output logic [CHANNELS-1:0]   pix,
  output logic [CHANNELS-1:0]   busy
);

  logic [WIDTH-1:0] gfx_new_q [CHANNELS];
  logic [WIDTH-1:0] gfx_new_d [CHANNELS];
  logic [WIDTH-1:0] gfx_old_q [CHANNELS];
  logic [WIDTH-1:0] gfx_old_d [CHANNELS];

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      gfx_new_q <= '{default: '0};
      gfx_old_q <= '{default: '0};
    end else begin
      gfx_new_q <= gfx_new_d;
      gfx_old_q <= gfx_old_d;
    end
  end

  // Old copies always take the pre-edge new value of the neighbouring channel.
  always_comb begin
    gfx_new_d = gfx_new_q;
    gfx_old_d = gfx_old_q;
    for (int k = 0; k < CHANNELS; k++) begin
      if (wr[k]) begin
        gfx_new_d[k]                  = d;
        gfx_old_d[(k + 1) % CHANNELS] = gfx_new_q[(k + 1) % CHANNELS];
      end
    end
  end

  for (genvar k = 0; k < CHANNELS; k++) begin : g_chan
    logic [WIDTH-1:0] sel;
    assign sel = vdel[k] ? gfx_old_q[k] : gfx_new_q[k];

    tia_graphics_serializer_channel #(
      .WIDTH (WIDTH)
    ) u_ser (
      .clk     (clk),
      .reset_n (reset_n),
      .sel     (sel),
      .refl    (refl[k]),
      .start   (start[k]),
      .scale   (scale[2*k +: 2]),
      .pix     (pix[k]),
      .busy    (busy[k])
    );
  end

endmodule
